// File: rtl/tc_pkg.sv
//------------------------------------------------------------------------------
// Module      : tc_pkg
// Description : Shared lamp encodings and FSM state type for the two-street
//               traffic controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tc_pkg;

    // One-hot lamp encodings, shared by both streets
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;

    // Controller phases: A green, A yellow tail, B green, B yellow tail
    typedef enum logic [1:0] {
        AG = 2'd0,
        AY = 2'd1,
        BG = 2'd2,
        BY = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tc_phase_timer.sv
//------------------------------------------------------------------------------
// Module      : tc_phase_timer
// Description : Saturating phase counter with synchronous clear and enable.
//               Counts up to a run-time limit and holds there.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tc_phase_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count
);

    // Clear has priority over counting so a new phase always starts at zero
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (enable && (count < limit)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/tc_mealy.sv
//------------------------------------------------------------------------------
// Module      : tc_mealy
// Description : Two-street Mealy traffic-light controller. The street in green
//               yields only when its own sensor is idle and its minimum green
//               time has elapsed; the yield cycle already shows yellow.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tc_mealy
    import tc_pkg::*;
#(
    parameter int MIN_GREEN    = 1,
    parameter int YELLOW_TICKS = 1
) (
    input  logic       CLK,
    input  logic       R,
    input  logic       T_A,
    input  logic       T_B,
    output logic [2:0] L_A,
    output logic [2:0] L_B
);

    // Counter only needs to reach the larger of the two phase limits
    localparam int C_MAX   = (MIN_GREEN > YELLOW_TICKS) ? MIN_GREEN : YELLOW_TICKS;
    localparam int C_CNT_W = (C_MAX > 1) ? $clog2(C_MAX) : 1;

    localparam logic [C_CNT_W-1:0] C_G_LAST = C_CNT_W'(MIN_GREEN - 1);
    // Last count of the yellow tail state (the Mealy yield cycle is the first yellow)
    localparam logic [C_CNT_W-1:0] C_Y_LAST = C_CNT_W'((YELLOW_TICKS > 1) ? (YELLOW_TICKS - 2) : 0);
    localparam logic               C_HAS_TAIL = (YELLOW_TICKS > 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [C_CNT_W-1:0]   w_cnt;
    logic [C_CNT_W-1:0]   w_limit;
    logic                 w_leave;
    logic                 w_clear;

    // State register: reset forces phase AG
    always_ff @(posedge CLK) begin
        if (!R) begin
            r_state <= AG;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and Mealy lamp outputs; reset overrides lamps to all-red
    always_comb begin
        w_state_next = r_state;
        w_limit      = '0;
        w_leave      = 1'b0;
        L_A          = RED;
        L_B          = RED;
        case (r_state)
            AG: begin
                w_limit = C_G_LAST;
                w_leave = !T_A && (w_cnt == C_G_LAST);
                L_A     = w_leave ? YELLOW : GREEN;
                if (w_leave) begin
                    w_state_next = C_HAS_TAIL ? AY : BG;
                end
            end
            AY: begin
                w_limit = C_Y_LAST;
                L_A     = YELLOW;
                if (w_cnt == C_Y_LAST) begin
                    w_state_next = BG;
                end
            end
            BG: begin
                w_limit = C_G_LAST;
                w_leave = !T_B && (w_cnt == C_G_LAST);
                L_B     = w_leave ? YELLOW : GREEN;
                if (w_leave) begin
                    w_state_next = C_HAS_TAIL ? BY : AG;
                end
            end
            BY: begin
                w_limit = C_Y_LAST;
                L_B     = YELLOW;
                if (w_cnt == C_Y_LAST) begin
                    w_state_next = AG;
                end
            end
            default: begin
                w_state_next = AG;
            end
        endcase
        if (!R) begin
            L_A = RED;
            L_B = RED;
        end
    end

    // Every phase change restarts the counter at zero
    assign w_clear = (w_state_next != r_state);

    tc_phase_timer #(
        .WIDTH (C_CNT_W)
    ) u_timer (
        .clk    (CLK),
        .rst_n  (R),
        .clear  (w_clear),
        .enable (1'b1),
        .limit  (w_limit),
        .count  (w_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_tc_mealy.sv
//------------------------------------------------------------------------------
// Module      : tb_tc_mealy
// Description : Self-checking bench for tc_mealy with default parameters and
//               with MIN_GREEN=3 / YELLOW_TICKS=2.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tc_mealy;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] X = 3'b100;

    typedef struct {
        logic       r;
        logic       ta;
        logic       tb;
        logic [2:0] la;
        logic [2:0] lb;
    } vec_t;

    logic       clk = 1'b0;
    logic       r1, ta1, tb1;
    logic       r3, ta3, tb3;
    logic [2:0] la1, lb1, la3, lb3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tc_mealy dut1 (
        .CLK (clk),
        .R   (r1),
        .T_A (ta1),
        .T_B (tb1),
        .L_A (la1),
        .L_B (lb1)
    );

    tc_mealy #(
        .MIN_GREEN    (3),
        .YELLOW_TICKS (2)
    ) dut3 (
        .CLK (clk),
        .R   (r3),
        .T_A (ta3),
        .T_B (tb3),
        .L_A (la3),
        .L_B (lb3)
    );

    function automatic vec_t mk(logic r, logic ta, logic tb, logic [2:0] la, logic [2:0] lb);
        vec_t v;
        v.r = r; v.ta = ta; v.tb = tb; v.la = la; v.lb = lb;
        return v;
    endfunction

    task automatic check3(string name, int idx, logic [2:0] act, logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
        end
    endtask

    // Drive one vector for a full cycle, compare before the next rising edge
    task automatic apply(int which, int idx, vec_t v);
        if (which == 1) begin
            r1 = v.r; ta1 = v.ta; tb1 = v.tb;
        end else begin
            r3 = v.r; ta3 = v.ta; tb3 = v.tb;
        end
        @(negedge clk);
        if (which == 1) begin
            check3("dflt_LA", idx, la1, v.la);
            check3("dflt_LB", idx, lb1, v.lb);
        end else begin
            check3("mg3_LA", idx, la3, v.la);
            check3("mg3_LB", idx, lb3, v.lb);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_legal(string name, int idx, logic [2:0] la, logic [2:0] lb);
        n_checks++;
        if (!$onehot(la) || !$onehot(lb) || ((la != X) && (lb != X))) begin
            n_fail++;
            $display("FAIL %s[%0d]: got L_A=%b L_B=%b required one-hot with a red street", name, idx, la, lb);
        end
    endtask

    vec_t t1[16];
    vec_t t3[28];

    initial begin
        r1 = 1'b0; ta1 = 1'b0; tb1 = 1'b0;
        r3 = 1'b0; ta3 = 1'b0; tb3 = 1'b0;

        // Default parameters: reset, sensor holding, Mealy yield, mid-phase reset
        t1[0]  = mk(0, 1, 0, X, X);
        t1[1]  = mk(0, 1, 1, X, X);
        t1[2]  = mk(1, 1, 0, G, X);
        t1[3]  = mk(1, 1, 1, G, X);
        t1[4]  = mk(1, 1, 1, G, X);
        t1[5]  = mk(1, 0, 1, Y, X);
        t1[6]  = mk(1, 0, 1, X, G);
        t1[7]  = mk(1, 1, 1, X, G);
        t1[8]  = mk(1, 1, 1, X, G);
        t1[9]  = mk(1, 1, 0, X, Y);
        t1[10] = mk(1, 1, 0, G, X);
        t1[11] = mk(1, 0, 0, Y, X);
        t1[12] = mk(1, 0, 0, X, Y);
        t1[13] = mk(1, 0, 0, Y, X);
        t1[14] = mk(0, 0, 0, X, X);
        t1[15] = mk(1, 1, 0, G, X);

        // MIN_GREEN=3, YELLOW_TICKS=2: timed phases, reset in AY and in BY
        t3[0]  = mk(0, 0, 0, X, X);
        t3[1]  = mk(0, 0, 0, X, X);
        t3[2]  = mk(1, 0, 0, G, X);
        t3[3]  = mk(1, 0, 0, G, X);
        t3[4]  = mk(1, 0, 0, Y, X);
        t3[5]  = mk(1, 0, 0, Y, X);
        t3[6]  = mk(1, 0, 0, X, G);
        t3[7]  = mk(1, 0, 0, X, G);
        t3[8]  = mk(1, 0, 0, X, Y);
        t3[9]  = mk(1, 0, 0, X, Y);
        t3[10] = mk(1, 0, 0, G, X);
        t3[11] = mk(1, 0, 0, G, X);
        t3[12] = mk(1, 0, 0, Y, X);
        t3[13] = mk(0, 0, 0, X, X);
        t3[14] = mk(1, 1, 0, G, X);
        t3[15] = mk(1, 1, 0, G, X);
        t3[16] = mk(1, 0, 0, Y, X);
        t3[17] = mk(1, 0, 0, Y, X);
        t3[18] = mk(1, 0, 0, X, G);
        t3[19] = mk(1, 0, 0, X, G);
        t3[20] = mk(1, 0, 0, X, Y);
        t3[21] = mk(0, 0, 0, X, X);
        t3[22] = mk(1, 0, 1, G, X);
        t3[23] = mk(1, 0, 1, G, X);
        t3[24] = mk(1, 1, 1, G, X);
        t3[25] = mk(1, 1, 1, G, X);
        t3[26] = mk(1, 1, 0, G, X);
        t3[27] = mk(1, 0, 0, Y, X);

        for (int i = 0; i < 16; i++) begin
            apply(1, i, t1[i]);
        end
        r1 = 1'b0;
        for (int i = 0; i < 28; i++) begin
            apply(3, i, t3[i]);
        end

        // Random sensors with occasional reset: lamp legality on both instances
        for (int i = 0; i < 10000; i++) begin
            r1  = ($urandom_range(0, 63) != 0);
            r3  = ($urandom_range(0, 63) != 0);
            ta1 = 1'($urandom_range(0, 1));
            tb1 = 1'($urandom_range(0, 1));
            ta3 = 1'($urandom_range(0, 1));
            tb3 = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_legal("rand_dflt", i, la1, lb1);
            check_legal("rand_mg3", i, la3, lb3);
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
